bd_tx_bridge: RTL

Clocked-to-asynchronous launch stage for the async RV32I datapath. Accepts words from the synchronous domain over a valid/ready interface and buffers them in a small FIFO. Issues each word as a four-phase bundled-data transfer (o_req/i_ack plus o_data). o_req is the signal routed through the matched delay element ahead of the first async pipeline stage; the bridge guarantees that o_data is stable before and throughout every request phase.

---
 rtl/bd_tx_bridge.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/bd_tx_bridge.sv
// bd_tx_bridge: launches words from the clocked domain into the async
// datapath. A small FIFO buffers incoming words. A four-phase bundled-data
// FSM drives o_req/o_data, and i_ack is sampled through a synchronizer.
// o_data is loaded only at a launch. It therefore stays stable from the
// SETUP cycle until the acknowledge has been released again.
module bd_tx_bridge #(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [DWIDTH-1:0]          i_data,
  output logic                       o_req,
  output logic [DWIDTH-1:0]          o_data,
  input  logic                       i_ack,
  output logic                       o_busy,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_proto_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT_HI,
    ST_WAIT_LO
  } state_e;

  state_e                  state_q, state_d;
  logic                    req_q, req_d;
  logic [DWIDTH-1:0]       data_q, data_d;
  logic                    proto_err_q, proto_err_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [DWIDTH-1:0]       mem_q [DEPTH];
  logic [DWIDTH-1:0]       mem_d [DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  logic                    ack_s;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic [DWIDTH-1:0]       head;

  assign ack_s = sync_q[SYNC_STAGES-1];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = i_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  assign o_ready     = !full;
  assign o_req       = req_q;
  assign o_data      = data_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_count     = count_q;
  assign o_proto_err = proto_err_q;

  // Shift i_ack through the synchronizer chain; the FSM sees only the last stage
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_ack};
  end

  // FIFO storage, pointer and occupancy update; pops are requested by the FSM
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Handshake FSM: launch a word, raise req, wait for ack high, then ack low.
  // WAIT_LO launches directly into SETUP when another word is queued.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          data_d  = head;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        req_d   = 1'b1;
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (!ack_s) begin
          if (!empty) begin
            pop     = 1'b1;
            data_d  = head;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky flag: an acknowledge seen when no request can be outstanding
  always_comb begin
    proto_err_d = proto_err_q ||
                  (ack_s && ((state_q == ST_IDLE) || (state_q == ST_SETUP)));
  end

  // Control and datapath registers; reset drops req at once and discards the FIFO
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      data_q      <= '0;
      proto_err_q <= 1'b0;
      sync_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      data_q      <= data_d;
      proto_err_q <= proto_err_d;
      sync_q      <= sync_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage array
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule
